nv_nvdla_rd_eg_elastic_pipe: RTL and testbench

//   Parametrised egress pipe stage for the read-return path (dma -> client rd_rsp).

---
 rtl/nv_nvdla_rd_eg_elastic_pipe.sv | 99 +++++++++
 tb/tb_nv_nvdla_rd_eg_elastic_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nv_nvdla_rd_eg_elastic_pipe.sv
// Read-return egress stage: DEPTH-entry FIFO feeding a flopped output register, optional idle bypass.
// Latency 1 cycle (BYPASS=1) or 2 cycles (BYPASS=0) when idle; in_rdy is a flop that never depends on out_rdy.
module nv_nvdla_rd_eg_elastic_pipe #(
  parameter int DW     = 514,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  localparam int OCCW  = $clog2(DEPTH + 2)
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [DW-1:0]   in_pd,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   out_pd,
  input  logic            flush,
  output logic [OCCW-1:0] occ
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [OCCW-1:0] r_cnt;
  logic            r_in_rdy;
  logic            r_out_vld;
  logic [DW-1:0]   r_out_pd;
  logic [OCCW-1:0] r_occ;

  logic            w_push;
  logic            w_ld;
  logic            w_empty;
  logic            w_byp;
  logic            w_wr;
  logic            w_rd;
  logic            w_vld_nxt;
  logic [OCCW-1:0] w_cnt_nxt;

  assign w_push    = in_vld & r_in_rdy;
  assign w_ld      = ~r_out_vld | out_rdy;
  assign w_empty   = (r_cnt == '0);
  // Bypass only when the FIFO is empty and the output register can take the word now.
  assign w_byp     = (BYPASS != 0) && w_empty && w_ld;
  assign w_wr      = w_push & ~w_byp;
  assign w_rd      = w_ld & ~w_empty;
  assign w_vld_nxt = w_ld ? (w_rd | (w_byp & w_push)) : r_out_vld;
  assign w_cnt_nxt = r_cnt + OCCW'(w_wr) - OCCW'(w_rd);

  always_ff @(posedge nvdla_core_clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= in_pd;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_out_pd  <= '0;
      r_occ     <= '0;
    end else if (flush) begin
      // out_pd deliberately keeps its last value across a flush.
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_occ     <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_rd) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_ld) begin
        r_out_vld <= w_vld_nxt;
        if (w_rd) begin
          r_out_pd <= r_mem[r_rp];
        end else if (w_byp & w_push) begin
          r_out_pd <= in_pd;
        end
      end
      r_cnt    <= w_cnt_nxt;
      r_in_rdy <= (w_cnt_nxt < OCCW'(DEPTH));
      r_occ    <= w_cnt_nxt + OCCW'(w_vld_nxt);
    end
  end

  assign in_rdy  = r_in_rdy;
  assign out_vld = r_out_vld;
  assign out_pd  = r_out_pd;
  assign occ     = r_occ;

endmodule

// File: tb/tb_nv_nvdla_rd_eg_elastic_pipe.sv
// Randomised bench: transaction-queue reference model for the bypass instance, order scoreboard for the FIFO-only instance.
module tb_nv_nvdla_rd_eg_elastic_pipe;
  localparam int DW    = 514;
  localparam int DEPTH = 4;
  localparam int OCCW  = $clog2(DEPTH + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_flush;
  logic [DW-1:0]   a_in_pd, a_out_pd;
  logic [OCCW-1:0] a_occ;
  logic            b_rst, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_flush;
  logic [DW-1:0]   b_in_pd, b_out_pd;
  logic [OCCW-1:0] b_occ;

  nv_nvdla_rd_eg_elastic_pipe #(.DW(DW), .DEPTH(DEPTH), .BYPASS(1)) u_a (
    .nvdla_core_clk(clk), .nvdla_core_rst(a_rst),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_pd(a_in_pd),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_pd(a_out_pd),
    .flush(a_flush), .occ(a_occ)
  );

  nv_nvdla_rd_eg_elastic_pipe #(.DW(DW), .DEPTH(DEPTH), .BYPASS(0)) u_b (
    .nvdla_core_clk(clk), .nvdla_core_rst(b_rst),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_pd(b_in_pd),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_pd(b_out_pd),
    .flush(b_flush), .occ(b_occ)
  );

  int total = 0;
  int bad   = 0;
  int a_acc = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_pd;
  logic [DW-1:0] bq[$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pd();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < (DW + 31) / 32; k++) v = {v[DW-33:0], 32'($urandom)};
    return v;
  endfunction

  // Model of the bypass instance: every held word is in one ordered queue whose head is the visible output.
  task automatic step_a(input logic vld, input logic [DW-1:0] pd, input logic ordy,
                        input logic fl, input logic rs);
    bit push, pop;
    a_in_vld = vld; a_in_pd = pd; a_out_rdy = ordy; a_flush = fl; a_rst = rs;
    push = vld && (mq.size() <= DEPTH);
    pop  = (mq.size() > 0) && ordy;
    if (vld && a_in_rdy && !rs && !fl) a_acc++;
    if (rs) begin
      mq.delete();
      m_pd = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pd);
    end
    if (mq.size() > 0) m_pd = mq[0];
    @(negedge clk);
    chk("a_occ", DW'(a_occ), DW'(mq.size()));
    chk("a_in_rdy", DW'(a_in_rdy), DW'(mq.size() <= DEPTH));
    chk("a_out_vld", DW'(a_out_vld), DW'(mq.size() > 0));
    if (mq.size() > 0 || rs || fl) chk("a_out_pd", a_out_pd, m_pd);
  endtask

  task automatic step_b(input logic vld, input logic [DW-1:0] pd, input logic ordy);
    b_in_vld = vld; b_in_pd = pd; b_out_rdy = ordy;
    if (b_out_vld && ordy) begin
      chk("b_pop_pd", b_out_pd, (bq.size() > 0) ? bq[0] : '1);
      if (bq.size() > 0) void'(bq.pop_front());
    end
    if (vld && b_in_rdy) bq.push_back(pd);
    @(negedge clk);
    chk("b_occ", DW'(b_occ), DW'(bq.size()));
  endtask

  initial begin
    a_rst = 1'b1; a_in_vld = 1'b0; a_in_pd = '0; a_out_rdy = 1'b0; a_flush = 1'b0;
    b_rst = 1'b1; b_in_vld = 1'b0; b_in_pd = '0; b_out_rdy = 1'b0; b_flush = 1'b0;
    m_pd = '0;
    @(negedge clk);

    // T1: reset held two cycles with in_vld asserted
    step_a(1'b1, DW'(32'h77), 1'b1, 1'b0, 1'b1);
    step_a(1'b1, DW'(32'h77), 1'b1, 1'b0, 1'b1);
    chk("t1_out_pd", a_out_pd, '0);

    // T2: back-to-back stream with downstream always ready
    for (int i = 1; i <= 16; i++) step_a(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // T3: full backpressure, then drain
    a_acc = 0;
    for (int i = 1; i <= 8; i++) step_a(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    chk("t3_accepted", DW'(a_acc), DW'(5));
    chk("t3_occ", DW'(a_occ), DW'(5));
    for (int i = 0; i < 6; i++) step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // T5: flush while full, with a word offered in the flush cycle
    for (int i = 1; i <= 6; i++) step_a(1'b1, DW'(32'h30 + i), 1'b0, 1'b0, 1'b0);
    step_a(1'b1, DW'(32'hEE), 1'b0, 1'b1, 1'b0);
    chk("t5_occ", DW'(a_occ), DW'(0));
    chk("t5_pd_hold", a_out_pd, DW'(32'h31));
    for (int i = 0; i < 3; i++) step_a(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // T6: four held (three in FIFO), then push and pop every cycle
    for (int i = 1; i <= 4; i++) step_a(1'b1, DW'(32'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 5; i <= 24; i++) step_a(1'b1, DW'(32'h40 + i), 1'b1, 1'b0, 1'b0);
    chk("t6_occ", DW'(a_occ), DW'(4));
    chk("t6_in_rdy", DW'(a_in_rdy), DW'(1));

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      logic ordy;
      ordy = i[8] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step_a($urandom_range(0, 3) != 0, rnd_pd(), ordy,
             $urandom_range(0, 99) == 0, $urandom_range(0, 999) == 0);
    end
    a_rst = 1'b0; a_in_vld = 1'b0; a_flush = 1'b0;

    // T4: FIFO-only instance, idle latency is two cycles
    b_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    chk("b_rst_occ", DW'(b_occ), DW'(0));
    chk("b_rst_vld", DW'(b_out_vld), DW'(0));
    step_b(1'b1, DW'(32'hAA), 1'b0);
    chk("t4_vld_c1", DW'(b_out_vld), DW'(0));
    step_b(1'b0, '0, 1'b0);
    chk("t4_vld_c2", DW'(b_out_vld), DW'(1));
    chk("t4_pd_c2", b_out_pd, DW'(32'hAA));
    step_b(1'b0, '0, 1'b1);
    chk("t4_drained", DW'(b_out_vld), DW'(0));

    for (int i = 0; i < 3000; i++) begin
      logic ordy;
      ordy = i[7] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step_b($urandom_range(0, 2) != 0, rnd_pd(), ordy);
      if (b_occ > OCCW'(DEPTH + 1)) chk("b_overflow", DW'(b_occ), DW'(DEPTH + 1));
    end
    for (int i = 0; i < 12; i++) step_b(1'b0, '0, 1'b1);
    chk("b_final_empty", DW'(bq.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
